// File: rtl/read_batch_loader_pkg.sv
// Shared types, sizes and address helpers for the ping-pong read batch loader.
package read_batch_loader_pkg;

    localparam int unsigned DATA_W         = 512;
    localparam int unsigned BEATS_PER_READ = 4;
    localparam int unsigned MAX_BATCH      = 256;
    localparam int unsigned BATCH_W        = 9;
    localparam int unsigned NUM_BANKS      = 2;

    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned READ_W = $clog2(MAX_BATCH);
    localparam int unsigned BEAT_W = $clog2(BEATS_PER_READ);

    // Buffer address width: bank | read | beat.
    function automatic int unsigned addr_width(input int unsigned banks,
                                               input int unsigned reads,
                                               input int unsigned beats);
        return $clog2(banks) + $clog2(reads) + $clog2(beats);
    endfunction

    localparam int unsigned ADDR_W = addr_width(NUM_BANKS, MAX_BATCH, BEATS_PER_READ);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_BUSY    = 2'd3
    } bank_state_e;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [READ_W-1:0] read;
        logic [BEAT_W-1:0] beat;
    } buf_addr_t;

endpackage

// File: rtl/read_batch_loader_if.sv
// Host load, engine offer/claim, engine read and error signals of the batch loader.
interface read_batch_loader_if;
    import read_batch_loader_pkg::*;

    logic                load_valid;
    logic [DATA_W-1:0]   load_data;
    logic [BATCH_W-1:0]  batch_size;
    logic                load_ready;
    logic                batch_valid;
    logic [BANK_W-1:0]   batch_bank;
    logic [BATCH_W-1:0]  batch_count;
    logic                batch_claim;
    logic                rd_en;
    logic [BATCH_W-1:0]  rd_read;
    logic [BEAT_W-1:0]   rd_beat;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_data_valid;
    logic                batch_release;
    logic                err_overflow;
    logic                err_size;

    modport slave (
        input  load_valid, load_data, batch_size, batch_claim,
               rd_en, rd_read, rd_beat, batch_release,
        output load_ready, batch_valid, batch_bank, batch_count,
               rd_data, rd_data_valid, err_overflow, err_size
    );

    modport master (
        output load_valid, load_data, batch_size, batch_claim,
               rd_en, rd_read, rd_beat, batch_release,
        input  load_ready, batch_valid, batch_bank, batch_count,
               rd_data, rd_data_valid, err_overflow, err_size
    );

endinterface

// File: rtl/read_batch_loader_rd_buf_ram.sv
// Simple dual-port batch buffer: fill side writes, engine side reads with one-cycle latency.
module rd_buf_ram #(
    parameter int unsigned DW = 512,
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    // Write port and registered read port; read data holds when not enabled.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/read_batch_loader.sv
// Ping-pong batch loader: host fills one bank while the engine consumes another.
module read_batch_loader
    import read_batch_loader_pkg::*;
(
    input  logic          Clk_32UI,
    input  logic          reset_BWT_extend,
    read_batch_loader_if.slave bus
);

    bank_state_e        r_bank_state [NUM_BANKS];
    bank_state_e        w_state_nxt  [NUM_BANKS];
    logic [BATCH_W-1:0] r_bank_count [NUM_BANKS];
    logic [BATCH_W-1:0] w_count_nxt  [NUM_BANKS];

    logic [BANK_W-1:0]  r_fill_bank, w_fill_nxt;
    logic [BANK_W-1:0]  r_eng_bank,  w_eng_nxt;
    logic [BANK_W-1:0]  r_rel_bank,  w_rel_nxt;
    logic [BATCH_W-1:0] r_read_idx,  w_read_nxt;
    logic [BEAT_W-1:0]  r_beat_idx,  w_beat_nxt;

    logic               r_batch_valid;
    logic [BATCH_W-1:0] r_batch_count;
    logic               r_rd_data_valid;
    logic               r_err_overflow;
    logic               r_err_size;

    logic               w_load_ready;
    logic               w_accept;
    logic               w_first;
    logic               w_last;
    logic               w_claim;
    logic               w_release;
    logic               w_size_zero;
    logic               w_size_big;
    logic [BATCH_W-1:0] w_eff_size;
    logic [BATCH_W-1:0] w_cur_size;
    logic               w_rd_en;
    buf_addr_t          w_wr_addr;
    buf_addr_t          w_rd_addr;
    logic [DATA_W-1:0]  w_rd_data;

    // Handshake qualification, batch-size sanitising and buffer addressing.
    always_comb begin
        w_load_ready = (r_bank_state[r_fill_bank] == BANK_EMPTY) ||
                       (r_bank_state[r_fill_bank] == BANK_FILLING);
        w_accept     = bus.load_valid && w_load_ready;
        w_first      = (r_bank_state[r_fill_bank] == BANK_EMPTY);
        w_size_zero  = (bus.batch_size == '0);
        w_size_big   = (bus.batch_size > BATCH_W'(MAX_BATCH));
        w_eff_size   = bus.batch_size;
        if (w_size_zero) begin
            w_eff_size = BATCH_W'(1);
        end else if (w_size_big) begin
            w_eff_size = BATCH_W'(MAX_BATCH);
        end
        // The size is only sampled on the first beat; later changes are ignored.
        w_cur_size   = w_first ? w_eff_size : r_bank_count[r_fill_bank];
        w_last       = (r_read_idx == (w_cur_size - BATCH_W'(1))) &&
                       (r_beat_idx == BEAT_W'(BEATS_PER_READ - 1));
        w_claim      = bus.batch_claim && r_batch_valid;
        w_release    = bus.batch_release && (r_bank_state[r_rel_bank] == BANK_BUSY);
        // Out-of-range read indices leave the previous read data in place.
        w_rd_en      = bus.rd_en && (bus.rd_read < BATCH_W'(MAX_BATCH));

        w_wr_addr.bank = r_fill_bank;
        w_wr_addr.read = r_read_idx[READ_W-1:0];
        w_wr_addr.beat = r_beat_idx;
        w_rd_addr.bank = r_rel_bank;
        w_rd_addr.read = bus.rd_read[READ_W-1:0];
        w_rd_addr.beat = bus.rd_beat;
    end

    // Next bank states and pointers from fill, claim and release events.
    always_comb begin
        for (int i = 0; i < int'(NUM_BANKS); i++) begin
            w_state_nxt[i] = r_bank_state[i];
            w_count_nxt[i] = r_bank_count[i];
        end
        w_fill_nxt = r_fill_bank;
        w_eng_nxt  = r_eng_bank;
        w_rel_nxt  = r_rel_bank;
        w_read_nxt = r_read_idx;
        w_beat_nxt = r_beat_idx;

        if (w_accept) begin
            if (w_first) begin
                w_count_nxt[r_fill_bank] = w_eff_size;
            end
            if (w_last) begin
                w_state_nxt[r_fill_bank] = BANK_FULL;
                w_fill_nxt = r_fill_bank + BANK_W'(1);
                w_read_nxt = '0;
                w_beat_nxt = '0;
            end else begin
                w_state_nxt[r_fill_bank] = BANK_FILLING;
                if (r_beat_idx == BEAT_W'(BEATS_PER_READ - 1)) begin
                    w_beat_nxt = '0;
                    w_read_nxt = r_read_idx + BATCH_W'(1);
                end else begin
                    w_beat_nxt = r_beat_idx + BEAT_W'(1);
                end
            end
        end

        // Claim acts on a FULL bank, release on a BUSY one, fill on EMPTY/FILLING:
        // the three can never target the same bank in one cycle.
        if (w_claim) begin
            w_state_nxt[r_eng_bank] = BANK_BUSY;
            w_eng_nxt = r_eng_bank + BANK_W'(1);
        end
        if (w_release) begin
            w_state_nxt[r_rel_bank] = BANK_EMPTY;
            w_rel_nxt = r_rel_bank + BANK_W'(1);
        end
    end

    // State, pointer and registered-output update with synchronous reset.
    always_ff @(posedge Clk_32UI) begin
        if (!reset_BWT_extend) begin
            for (int i = 0; i < int'(NUM_BANKS); i++) begin
                r_bank_state[i] <= BANK_EMPTY;
                r_bank_count[i] <= '0;
            end
            r_fill_bank     <= '0;
            r_eng_bank      <= '0;
            r_rel_bank      <= '0;
            r_read_idx      <= '0;
            r_beat_idx      <= '0;
            r_batch_valid   <= 1'b0;
            r_batch_count   <= '0;
            r_rd_data_valid <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_size      <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_BANKS); i++) begin
                r_bank_state[i] <= w_state_nxt[i];
                r_bank_count[i] <= w_count_nxt[i];
            end
            r_fill_bank     <= w_fill_nxt;
            r_eng_bank      <= w_eng_nxt;
            r_rel_bank      <= w_rel_nxt;
            r_read_idx      <= w_read_nxt;
            r_beat_idx      <= w_beat_nxt;
            r_batch_valid   <= (w_state_nxt[w_eng_nxt] == BANK_FULL);
            r_batch_count   <= w_count_nxt[w_eng_nxt];
            r_rd_data_valid <= bus.rd_en;
            if (bus.load_valid && !w_load_ready) begin
                r_err_overflow <= 1'b1;
            end
            if (w_accept && w_first && (w_size_zero || w_size_big)) begin
                r_err_size <= 1'b1;
            end
        end
    end

    rd_buf_ram #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) u_ram (
        .clk       (Clk_32UI),
        .i_wr_en   (w_accept),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (bus.load_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign bus.load_ready    = w_load_ready;
    assign bus.batch_valid   = r_batch_valid;
    assign bus.batch_bank    = r_eng_bank;
    assign bus.batch_count   = r_batch_count;
    assign bus.rd_data       = w_rd_data;
    assign bus.rd_data_valid = r_rd_data_valid;
    assign bus.err_overflow  = r_err_overflow;
    assign bus.err_size      = r_err_size;

endmodule

// File: tb/tb_read_batch_loader.sv
// Scoreboard bench for read_batch_loader: stimulus pushes expected offers and read data,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_read_batch_loader;
    import read_batch_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    read_batch_loader_if bus();

    read_batch_loader dut (
        .Clk_32UI         (clk),
        .reset_BWT_extend (rst_n),
        .bus              (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] q_rd[$];
    int unsigned       q_bank[$];
    int unsigned       q_cnt[$];
    bit                offer_seen = 1'b0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DATA_W-1:0] mk(input int unsigned tag);
        logic [31:0] w;
        w = 32'hA5A50000 ^ tag;
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic beat(input int unsigned tag, input int unsigned size);
        bus.load_valid = 1'b1;
        bus.load_data  = mk(tag);
        bus.batch_size = BATCH_W'(size);
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic batch(input int unsigned first_tag, input int unsigned n, input int unsigned size);
        for (int i = 0; i < int'(n); i++) beat(first_tag + i, size);
    endtask

    task automatic claim();
        bus.batch_claim = 1'b1;
        tick();
        bus.batch_claim = 1'b0;
    endtask

    task automatic release_bank();
        bus.batch_release = 1'b1;
        tick();
        bus.batch_release = 1'b0;
    endtask

    task automatic rd(input int unsigned r, input int unsigned b, input int unsigned exp_tag);
        q_rd.push_back(mk(exp_tag));
        bus.rd_en   = 1'b1;
        bus.rd_read = BATCH_W'(r);
        bus.rd_beat = BEAT_W'(b);
        tick();
        bus.rd_en   = 1'b0;
    endtask

    task automatic push_offer(input int unsigned b, input int unsigned c);
        q_bank.push_back(b);
        q_cnt.push_back(c);
    endtask

    // Monitor: compare read data and each new batch offer against the scoreboard.
    always @(negedge clk) begin
        if (bus.rd_data_valid) begin
            if (q_rd.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got %0h expected no read data", bus.rd_data);
            end else begin
                chk("rd_data", bus.rd_data, q_rd.pop_front());
            end
        end
        if (bus.batch_valid && !offer_seen) begin
            if (q_bank.size() == 0) begin
                n_checks++;
                $display("FAIL offer_unexpected: got bank %0d count %0d expected no offer",
                         bus.batch_bank, bus.batch_count);
            end else begin
                chk("offer_bank",  DATA_W'(bus.batch_bank),  DATA_W'(q_bank.pop_front()));
                chk("offer_count", DATA_W'(bus.batch_count), DATA_W'(q_cnt.pop_front()));
            end
            offer_seen = 1'b1;
        end
        if (!bus.batch_valid || bus.batch_claim || !rst_n) offer_seen = 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        bus.load_valid    = 1'b0;
        bus.load_data     = '0;
        bus.batch_size    = '0;
        bus.batch_claim   = 1'b0;
        bus.rd_en         = 1'b0;
        bus.rd_read       = '0;
        bus.rd_beat       = '0;
        bus.batch_release = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_load_ready",  bus.load_ready,    1);
        chk("rst_batch_valid", bus.batch_valid,   0);
        chk("rst_batch_bank",  bus.batch_bank,    0);
        chk("rst_batch_count", bus.batch_count,   0);
        chk("rst_rd_valid",    bus.rd_data_valid, 0);
        chk("rst_err_ovf",     bus.err_overflow,  0);
        chk("rst_err_size",    bus.err_size,      0);

        // 1: size 3, 12 back-to-back beats into bank 0, then read back.
        push_offer(0, 3);
        batch(1, 11, 3);
        chk("s1_valid_early", bus.batch_valid, 0);
        beat(12, 3);
        chk("s1_valid", bus.batch_valid, 1);
        chk("s1_err_size", bus.err_size, 0);
        claim();
        rd(1, 3, 8);
        rd(0, 0, 1);
        rd(2, 3, 12);
        release_bank();
        tick();
        chk("s1_ready", bus.load_ready, 1);

        // 2: two full banks with no claim, third batch overflows.
        do_reset();
        push_offer(0, 3);
        batch(101, 24, 3);
        chk("s2_ready_low", bus.load_ready, 0);
        chk("s2_ovf_before", bus.err_overflow, 0);
        beat(125, 3);
        chk("s2_ovf", bus.err_overflow, 1);
        chk("s2_ready_still_low", bus.load_ready, 0);
        tick();
        chk("s2_ovf_sticky", bus.err_overflow, 1);

        // 3: release of bank 0 in the same cycle as bank 1's last beat.
        do_reset();
        push_offer(0, 3);
        batch(201, 12, 3);
        tick();
        claim();
        push_offer(1, 3);
        batch(213, 11, 3);
        bus.batch_release = 1'b1;
        beat(224, 3);
        bus.batch_release = 1'b0;
        chk("s3_ready", bus.load_ready, 1);
        chk("s3_valid", bus.batch_valid, 1);
        chk("s3_bank", bus.batch_bank, 1);
        claim();
        rd(2, 3, 224);
        push_offer(0, 1);
        batch(301, 4, 1);
        tick();
        chk("s3_ready_busy", bus.load_ready, 0);
        // Claim bank 0 while releasing bank 1.
        bus.batch_claim   = 1'b1;
        bus.batch_release = 1'b1;
        tick();
        bus.batch_claim   = 1'b0;
        bus.batch_release = 1'b0;
        chk("s3_ready_freed", bus.load_ready, 1);
        chk("s3_valid_claimed", bus.batch_valid, 0);
        rd(0, 2, 303);
        tick();

        // 4: size 0 becomes 1; size 300 clamps to 256 (later size changes ignored).
        do_reset();
        push_offer(0, 1);
        batch(401, 4, 0);
        tick();
        chk("s4_err_size_zero", bus.err_size, 1);
        do_reset();
        chk("s4_err_cleared", bus.err_size, 0);
        push_offer(0, 256);
        beat(500, 300);
        for (int i = 1; i < 1024; i++) beat(500 + i, 5);
        tick();
        chk("s4_err_size_big", bus.err_size, 1);
        claim();
        rd(255, 3, 1523);
        rd(0, 0, 500);
        release_bank();

        // 5: valid toggling every cycle yields the same contents as scenario 1.
        do_reset();
        push_offer(0, 3);
        for (int i = 1; i <= 12; i++) begin
            beat(i, 3);
            if (i == 11) chk("s5_valid_early", bus.batch_valid, 0);
            tick();
        end
        chk("s5_valid", bus.batch_valid, 1);
        claim();
        for (int r = 0; r < 3; r++)
            for (int b = 0; b < 4; b++)
                rd(r, b, 1 + r * 4 + b);
        release_bank();

        // 6: reset after beat 6 discards the partial batch.
        do_reset();
        batch(601, 6, 3);
        do_reset();
        chk("s6_ready", bus.load_ready, 1);
        chk("s6_valid", bus.batch_valid, 0);
        chk("s6_ovf", bus.err_overflow, 0);
        chk("s6_size", bus.err_size, 0);
        push_offer(0, 3);
        batch(701, 12, 3);
        chk("s6_valid_after", bus.batch_valid, 1);
        tick();
        claim();
        rd(0, 0, 701);
        rd(2, 1, 710);
        release_bank();

        tick();
        tick();
        chk("end_rd_queue",    q_rd.size(),   0);
        chk("end_offer_queue", q_bank.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
